// File: rtl/aes_inv_round.sv
// One AES-128 decryption round, three register stages, one block per clock.
// The round key rides the pipeline so it leaves aligned with the result.

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign y = TBL[11'd2047 - {a, 3'b000} -: 8];
endmodule

module aes_inv_round #(
  parameter bit LAST_ROUND = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_valid_in,
  input  logic         key_valid_in,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out,
  output logic [127:0] key_out,
  output logic         valid_out
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  logic         accept_s;
  logic [127:0] sub_s;
  logic [127:0] mix_s;
  logic [127:0] s1_r, s2_r, s3_r;
  logic [127:0] k1_r, k2_r, k3_r;
  logic         v1_r, v2_r, v3_r;

  assign accept_s = data_valid_in & key_valid_in;

  // Output byte (row r, col c) takes input byte (row r, col c-r): row r rotated right by r.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    inv_sbox u_sbox (
      .a (data_in[127-8*SRC -: 8]),
      .y (sub_s[127-8*i -: 8])
    );
  end

  // Stage-3 mixing; the final round passes the keyed state straight through.
  always_comb begin
    mix_s = s2_r;
    if (LAST_ROUND == 1'b0) begin
      for (int c = 0; c < 4; c++) begin
        mix_s[127-32*c -: 32] = inv_mix_col(s2_r[127-32*c -: 32]);
      end
    end else begin
      mix_s = s2_r;
    end
  end

  // Pipeline registers; data only moves behind a valid beat so idle outputs hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
      s1_r <= 128'h0;
      s2_r <= 128'h0;
      s3_r <= 128'h0;
      k1_r <= 128'h0;
      k2_r <= 128'h0;
      k3_r <= 128'h0;
    end else begin
      v1_r <= accept_s;
      v2_r <= v1_r;
      v3_r <= v2_r;
      if (accept_s) begin
        s1_r <= sub_s;
        k1_r <= key_in;
      end
      if (v1_r) begin
        s2_r <= s1_r ^ k1_r;
        k2_r <= k1_r;
      end
      if (v2_r) begin
        s3_r <= mix_s;
        k3_r <= k2_r;
      end
    end
  end

  assign data_out  = s3_r;
  assign key_out   = k3_r;
  assign valid_out = v3_r;

endmodule

// File: tb/tb_aes_inv_round.sv
// Bench for aes_inv_round: a normal round and a final round driven side by side,
// checked against an independent GF(2^8) model through a cycle-stamped scoreboard.

module tb_aes_inv_round;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid_in = 1'b0;
  logic         key_valid_in = 1'b0;
  logic [127:0] data_in = 128'h0;
  logic [127:0] key_in = 128'h0;
  logic [127:0] data_out0, key_out0, data_out1, key_out1;
  logic         valid_out0, valid_out1;

  always #5 clk = ~clk;

  aes_inv_round #(.LAST_ROUND(1'b0)) u_mid (
    .clk(clk), .reset(reset), .data_valid_in(data_valid_in), .key_valid_in(key_valid_in),
    .data_in(data_in), .key_in(key_in), .data_out(data_out0), .key_out(key_out0),
    .valid_out(valid_out0)
  );

  aes_inv_round #(.LAST_ROUND(1'b1)) u_last (
    .clk(clk), .reset(reset), .data_valid_in(data_valid_in), .key_valid_in(key_valid_in),
    .data_in(data_in), .key_in(key_in), .data_out(data_out1), .key_out(key_out1),
    .valid_out(valid_out1)
  );

  typedef struct {
    int           due;
    logic [127:0] exp0;
    logic [127:0] exp1;
    logic [127:0] key;
  } sb_t;

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] exp0;
    logic [127:0] exp1;
  } vec_t;

  sb_t        sb_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] inv_tbl [256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input bit last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = inv_tbl[b[r+4*((c-r+4)%4)]] ^ k[127-8*(r+4*c) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (!last) begin
        t[4*c]   = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
        t[4*c+1] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
        t[4*c+2] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
        t[4*c+3] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sets the inputs for the coming edge; a full pair is scheduled three cycles on.
  task automatic apply(input logic dv, input logic kv, input logic [127:0] d, input logic [127:0] k,
                       input logic [127:0] e0, input logic [127:0] e1);
    sb_t s;
    data_valid_in = dv;
    key_valid_in  = kv;
    data_in       = d;
    key_in        = k;
    if (dv && kv) begin
      s.due = cyc + 3; s.exp0 = e0; s.exp1 = e1; s.key = k;
      sb_q.push_back(s);
    end
  endtask

  task automatic beat(input logic [127:0] d, input logic [127:0] k);
    apply(1'b1, 1'b1, d, k, model(d, k, 1'b0), model(d, k, 1'b1));
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 128'h0, 128'h0, 128'h0, 128'h0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " data_out mid"}, data_out0, 128'h0);
    chk({name, " key_out mid"}, key_out0, 128'h0);
    chk({name, " data_out last"}, data_out1, 128'h0);
    chk({name, " key_out last"}, key_out1, 128'h0);
    chk({name, " valid_out"}, {126'h0, valid_out0, valid_out1}, 128'h0);
  endtask

  // Output monitor: every valid pulse must match the oldest pending beat and its due cycle.
  always @(negedge clk) begin
    sb_t s;
    if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing: no valid_out at cycle %0d, expected one", sb_q[0].due);
      void'(sb_q.pop_front());
    end
    if (valid_out0 || valid_out1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected: valid_out mid=%b last=%b at cycle %0d, expected none",
                 valid_out0, valid_out1, cyc);
      end else begin
        s = sb_q.pop_front();
        chk("valid both", {126'h0, valid_out0, valid_out1}, 128'h3);
        chk("latency", 128'(cyc), 128'(s.due));
        chk("data_out mid", data_out0, s.exp0);
        chk("data_out last", data_out1, s.exp1);
        chk("key_out mid", key_out0, s.key);
        chk("key_out last", key_out1, s.key);
      end
    end
  end

  initial begin
    vec_t       vecs [8];
    logic [7:0] g, sb;

    // Inverse S-box derived from field inversion plus the forward affine map.
    for (int x = 0; x < 256; x++) begin
      g = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) g = 8'(y);
      sb = g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
      inv_tbl[sb] = 8'(x);
    end

    vecs[0].data = 128'h6353e08c0960e104cd70b751bacad0e7;
    vecs[0].key  = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[1].data = {16{8'h52}}; vecs[1].key = {4{32'h8e4da1bc}};
    vecs[2].data = {16{8'h52}}; vecs[2].key = {4{32'hf20a225c}};
    vecs[3].data = {16{8'h52}}; vecs[3].key = {4{32'h01010101}};
    vecs[4].data = {16{8'h52}}; vecs[4].key = {4{32'h00000000}};
    vecs[5].data = {16{8'h00}}; vecs[5].key = {16{8'hff}};
    vecs[6].data = {$urandom, $urandom, $urandom, $urandom};
    vecs[6].key  = {$urandom, $urandom, $urandom, $urandom};
    vecs[7].data = {$urandom, $urandom, $urandom, $urandom};
    vecs[7].key  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      vecs[i].exp0 = model(vecs[i].data, vecs[i].key, 1'b0);
      vecs[i].exp1 = model(vecs[i].data, vecs[i].key, 1'b1);
    end
    vecs[0].exp1 = 128'h00112233445566778899aabbccddeeff;

    #1;
    chk_zero("reset");
    step();
    step();
    reset = 1'b0;
    repeat (3) step();

    // Table vectors back to back.
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b1, vecs[i].data, vecs[i].key, vecs[i].exp0, vecs[i].exp1);
      step();
    end
    idle();
    repeat (5) step();

    // Data without key, then key without data: both dropped; then one real pair.
    apply(1'b1, 1'b0, vecs[1].data, vecs[1].key, 128'h0, 128'h0);
    step();
    apply(1'b0, 1'b1, vecs[2].data, vecs[2].key, 128'h0, 128'h0);
    step();
    beat(vecs[3].data, vecs[3].key);
    step();
    idle();
    repeat (5) step();

    // Asynchronous reset with three beats in flight.
    beat(vecs[6].data, vecs[6].key);
    step();
    beat(vecs[7].data, vecs[7].key);
    step();
    beat(vecs[1].data, vecs[1].key);
    step();
    idle();
    #2;
    chk("pre-reset valid", {127'h0, valid_out0}, 128'h1);
    reset = 1'b1;
    #1;
    chk_zero("async reset");
    sb_q.delete();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      #3;
      chk_zero("idle after reset");
    end

    // Beat presented in the same cycle reset is released.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    beat(vecs[0].data, vecs[0].key);
    step();
    idle();

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still pending, expected 0", sb_q.size());
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
